// File: rtl/bcd_disp_scan.sv
// Three-digit multiplexed common-anode seven-segment driver for BCD input.
// Frame-synchronous commit, leading-zero blanking and per-slot dead time.
module bcd_disp_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD        = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] BCD_0,
  input  logic [3:0] BCD_1,
  input  logic [3:0] BCD_2,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame
);

  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;
  localparam logic [2:0]    AN_OFF   = 3'b111;

  typedef enum logic [0:0] {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]    idx_r, idx_nxt_s;
  logic [11:0]   hold_r, hold_nxt_s;
  logic [11:0]   disp_r, disp_nxt_s;
  state_t        state_r, state_nxt_s;
  logic [6:0]    seg_r, seg_nxt_s;
  logic [2:0]    an_r, an_nxt_s;
  logic          frame_r, frame_nxt_s;
  logic          cnt_wrap_s;
  logic          commit_s;
  logic [3:0]    digit_s;
  logic          blank_s;
  logic [2:0]    an_sel_s;
  logic          lz_d2_s;
  logic          lz_d1_s;

  assign seg   = seg_r;
  assign an    = an_r;
  assign frame = frame_r;

  // Slot counter, digit index and the holding/display data path.
  always_comb begin
    cnt_wrap_s = (cnt_r == CNT_LAST);
    if (cnt_wrap_s) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
    idx_nxt_s = idx_r;
    if (cnt_wrap_s) begin
      if (idx_r == 2'd2) begin
        idx_nxt_s = 2'd0;
      end else begin
        idx_nxt_s = idx_r + 2'd1;
      end
    end else begin
      idx_nxt_s = idx_r;
    end
    // A load on the commit edge lands in holding only; display takes the old value.
    commit_s = cnt_wrap_s && (idx_r == 2'd2);
    if (commit_s) begin
      disp_nxt_s = hold_r;
    end else begin
      disp_nxt_s = disp_r;
    end
    if (load) begin
      hold_nxt_s = {BCD_2, BCD_1, BCD_0};
    end else begin
      hold_nxt_s = hold_r;
    end
  end

  // Per-slot GAP/ON state transitions.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_GAP: begin
        if (cnt_nxt_s >= CNT_DEAD) begin
          state_nxt_s = ST_ON;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_ON: begin
        if (cnt_wrap_s && (CNT_DEAD != '0)) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_ON;
        end
      end
      default: state_nxt_s = ST_GAP;
    endcase
  end

  // Output decode computed from next-state values so outputs align with cnt/idx.
  always_comb begin
    lz_d2_s  = blank_lz && (disp_nxt_s[11:8] == 4'd0);
    lz_d1_s  = lz_d2_s && (disp_nxt_s[7:4] == 4'd0);
    digit_s  = 4'd0;
    blank_s  = 1'b1;
    an_sel_s = AN_OFF;
    case (idx_nxt_s)
      2'd0: begin
        digit_s  = disp_nxt_s[3:0];
        blank_s  = 1'b0;
        an_sel_s = 3'b110;
      end
      2'd1: begin
        digit_s  = disp_nxt_s[7:4];
        blank_s  = lz_d1_s;
        an_sel_s = 3'b101;
      end
      2'd2: begin
        digit_s  = disp_nxt_s[11:8];
        blank_s  = lz_d2_s;
        an_sel_s = 3'b011;
      end
      default: begin
        digit_s  = 4'd0;
        blank_s  = 1'b1;
        an_sel_s = AN_OFF;
      end
    endcase
    if (state_nxt_s == ST_ON) begin
      an_nxt_s = an_sel_s;
      if (blank_s) begin
        seg_nxt_s = SEG_OFF;
      end else begin
        seg_nxt_s = seg7_decode(digit_s);
      end
    end else begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_OFF;
    end
    frame_nxt_s = (cnt_nxt_s == '0) && (idx_nxt_s == 2'd0);
  end

  // State and output registers; reset abandons the scan and any pending value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      idx_r   <= 2'd0;
      hold_r  <= 12'd0;
      disp_r  <= 12'd0;
      state_r <= ST_GAP;
      seg_r   <= SEG_OFF;
      an_r    <= AN_OFF;
      frame_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      hold_r  <= hold_nxt_s;
      disp_r  <= disp_nxt_s;
      state_r <= state_nxt_s;
      seg_r   <= seg_nxt_s;
      an_r    <= an_nxt_s;
      frame_r <= frame_nxt_s;
    end
  end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Directed bench for bcd_disp_scan: vector table plus hand-written multi-cycle sequences.
module tb_bcd_disp_scan;

  localparam int RD = 8;
  localparam int DD = 2;
  localparam int FR = 3 * RD;
  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] Z0  = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] BCD_0, BCD_1, BCD_2;
  logic       load;
  logic       blank_lz;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [3:0] b2, b1, b0;
    logic       lz;
    logic [6:0] e0, e1, e2;
  } vec_t;

  vec_t tbl [9];

  bcd_disp_scan #(.REFRESH_DIV(RD), .DEAD(DD)) dut (
    .clk(clk), .rst_n(rst_n), .BCD_0(BCD_0), .BCD_1(BCD_1), .BCD_2(BCD_2),
    .load(load), .blank_lz(blank_lz), .seg(seg), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_an(input int o);
    if ((o % RD) < DD) return 3'b111;
    case (o / RD)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int o, input logic [6:0] e0, input logic [6:0] e1,
                                         input logic [6:0] e2);
    if ((o % RD) < DD) return OFF;
    case (o / RD)
      0:       return e0;
      1:       return e1;
      default: return e2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the next frame-pulse cycle; n = cycles waited.
  task automatic wait_frame(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (frame === 1'b1) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL frame_timeout: got no frame pulse in 60 cycles, required one");
  endtask

  // Checks every cycle from frame offset 'start' through the end of the frame.
  task automatic check_frame(input string nm, input int start, input logic [6:0] e0,
                             input logic [6:0] e1, input logic [6:0] e2);
    for (int o = start; o < FR; o++) begin
      if (o > start) @(negedge clk);
      chk($sformatf("%s_an@%0d", nm, o), {4'b0, an}, {4'b0, exp_an(o)});
      chk($sformatf("%s_seg@%0d", nm, o), seg, exp_seg(o, e0, e1, e2));
      chk($sformatf("%s_frame@%0d", nm, o), {6'b0, frame}, {6'b0, (o == 0)});
    end
  endtask

  task automatic do_load(input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0);
    BCD_2 = b2;
    BCD_1 = b1;
    BCD_0 = b0;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int n;
    int lat;

    tbl[0] = '{"lz_007",   4'd0, 4'd0, 4'd7, 1'b1, 7'b1111000, OFF,        OFF};
    tbl[1] = '{"nolz_007", 4'd0, 4'd0, 4'd7, 1'b0, 7'b1111000, Z0,         Z0};
    tbl[2] = '{"lz_100",   4'd1, 4'd0, 4'd0, 1'b1, Z0,         Z0,         7'b1111001};
    tbl[3] = '{"lz_0c3",   4'd0, 4'hC, 4'd3, 1'b1, 7'b0110000, 7'b0111111, OFF};
    tbl[4] = '{"nolz_0c3", 4'd0, 4'hC, 4'd3, 1'b0, 7'b0110000, 7'b0111111, Z0};
    tbl[5] = '{"nolz_864", 4'd8, 4'd6, 4'd4, 1'b0, 7'b0011001, 7'b0000010, 7'b0000000};
    tbl[6] = '{"lz_019",   4'd0, 4'd1, 4'd9, 1'b1, 7'b0010000, 7'b1111001, OFF};
    tbl[7] = '{"lz_f00",   4'hF, 4'd0, 4'd0, 1'b1, Z0,         Z0,         7'b0111111};
    tbl[8] = '{"lz_000",   4'd0, 4'd0, 4'd0, 1'b1, Z0,         OFF,        OFF};

    rst_n = 1'b0; load = 1'b0; BCD_0 = 4'd0; BCD_1 = 4'd0; BCD_2 = 4'd0; blank_lz = 1'b1;

    // Reset state and first scan after release
    step(3);
    chk("reset_an", {4'b0, an}, 7'b0000111);
    chk("reset_seg", seg, OFF);
    chk("reset_frame", {6'b0, frame}, 7'd0);
    rst_n = 1'b1;
    step(1);
    check_frame("scan", 1, Z0, OFF, OFF);
    wait_frame(n);
    chk("first_frame_delay", 7'(n + FR - 1), 7'(FR));
    check_frame("scan2", 0, Z0, OFF, OFF);
    wait_frame(n);
    chk("frame_period", 7'(n + FR - 1), 7'(FR));

    // Load 2/5/5 mid-frame: old display holds until the wrap, then latency to d0 ON
    step(5);
    do_load(4'd2, 4'd5, 4'd5);
    for (lat = 1; lat < 40; lat++) begin
      if (an === 3'b110 && seg === 7'b0010010) break;
      if (lat < 19) begin
        chk($sformatf("hold_old_an@%0d", lat + 5), {4'b0, an}, {4'b0, exp_an(lat + 5)});
        chk($sformatf("hold_old_seg@%0d", lat + 5), seg, exp_seg(lat + 5, Z0, OFF, OFF));
      end
      @(negedge clk);
    end
    chk("load_latency", 7'(lat), 7'd21);
    check_frame("load255", 2, 7'b0010010, 7'b0010010, 7'b0100100);

    // Table of load/blanking/decode vectors
    for (int i = 0; i < 9; i++) begin
      wait_frame(n);
      step(5);
      blank_lz = tbl[i].lz;
      do_load(tbl[i].b2, tbl[i].b1, tbl[i].b0);
      wait_frame(n);
      check_frame(tbl[i].name, 0, tbl[i].e0, tbl[i].e1, tbl[i].e2);
    end

    // Load coincident with the commit edge
    wait_frame(n);
    step(5);
    blank_lz = 1'b0;
    do_load(4'd1, 4'd2, 4'd3);
    step(17);
    BCD_2 = 4'd9; BCD_1 = 4'd9; BCD_0 = 4'd9; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_frame("wrap_old", 0, 7'b0110000, 7'b0100100, 7'b1111001);
    wait_frame(n);
    check_frame("wrap_new", 0, 7'b0010000, 7'b0010000, 7'b0010000);

    // Two loads in one frame: last wins
    wait_frame(n);
    step(3);
    do_load(4'd4, 4'd5, 4'd6);
    step(6);
    do_load(4'd7, 4'd0, 4'd8);
    wait_frame(n);
    check_frame("two_loads", 0, 7'b0000000, Z0, 7'b1111000);

    // Reset during d1 ON with a pending value in holding
    wait_frame(n);
    step(5);
    do_load(4'd5, 4'd5, 4'd5);
    step(6);
    chk("pre_reset_an", {4'b0, an}, 7'b0000101);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_an", {4'b0, an}, 7'b0000111);
    chk("midrst_seg", seg, OFF);
    chk("midrst_frame", {6'b0, frame}, 7'd0);
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    check_frame("post_reset", 1, Z0, Z0, Z0);
    wait_frame(n);
    chk("post_reset_frame_delay", 7'(n + FR - 1), 7'(FR));
    check_frame("post_reset2", 0, Z0, Z0, Z0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
